// File: rtl/lcd_pkg.sv
// Shared constants, state codes and slot helpers for the character-LCD refresh scheduler.
package lcd_pkg;

   localparam int CHARS  = 16;
   localparam int CH_W   = 9;
   localparam int LINE_W = CHARS * CH_W;
   localparam int INIT_LEN = 4;

   localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
   localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
   localparam logic [7:0] LCD_CLEAR      = 8'h01;
   localparam logic [7:0] LCD_ENTRY      = 8'h06;
   localparam logic [7:0] LCD_LINE1_ADDR = 8'h80;
   localparam logic [7:0] LCD_LINE2_ADDR = 8'hC0;

   typedef logic [2:0] state_t;
   localparam state_t S_INIT   = 3'd0;
   localparam state_t S_IDLE   = 3'd1;
   localparam state_t S_CURSOR = 3'd2;
   localparam state_t S_CHAR   = 3'd3;
   localparam state_t S_SEND   = 3'd4;
   localparam state_t S_WAIT   = 3'd5;
   localparam state_t S_SETTLE = 3'd6;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_DISP_ON;
         2'd2:    return LCD_CLEAR;
         default: return LCD_ENTRY;
      endcase
   endfunction

   // Char 0 sits in the most significant slot of the line bus.
   function automatic logic [CH_W-1:0] get_slot(input logic [LINE_W-1:0] line,
                                                input logic [3:0]        idx);
      return line[(LINE_W - 1) - int'(idx) * CH_W -: CH_W];
   endfunction

endpackage

// File: rtl/lcd_settle_timer.sv
// Settle delay between LCD byte writes: counts 0..DLY_CYCLES-1 after a start pulse.
module lcd_settle_timer #(
   parameter int DLY_CYCLES = 262142
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic start,
   output logic expired
);

   localparam logic [17:0] LAST = 18'(DLY_CYCLES - 1);

   logic [17:0] count;
   logic        running;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         count   <= '0;
         running <= 1'b1;
      end else if (running) begin
         if (count == LAST) begin
            count   <= '0;
            running <= 1'b0;
         end else begin
            count <= count + 18'd1;
         end
      end
   end

   assign expired = running && (count == LAST);

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Runs the HD44780 init list, then redraws each LCD line only when its content
// changes or a redraw is forced, driving a start/done byte writer.
module lcd_refresh_scheduler
   import lcd_pkg::*;
#(
   parameter int DLY_CYCLES = 262142
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [LINE_W-1:0] iLine1,
   input  logic [LINE_W-1:0] iLine2,
   input  logic              iRefresh,
   input  logic              iDone,
   output logic [7:0]        oData,
   output logic              oRS,
   output logic              oStart,
   output logic              oBusy,
   output logic              oInitDone
);

   state_t            state;
   state_t            ret_state;
   logic [2:0]        init_idx;
   logic [3:0]        char_idx;
   logic [1:0]        force_dirty;
   logic [LINE_W-1:0] shadow1;
   logic [LINE_W-1:0] shadow2;
   logic [LINE_W-1:0] snap;
   logic              sel_line;
   logic              last_line;
   logic [7:0]        tx_byte;
   logic              tx_rs;

   logic              dirty1;
   logic              dirty2;
   logic              pick_line;
   logic              settle_start;
   logic              settle_expired;
   logic [CH_W-1:0]   cur_slot;

   assign dirty1       = force_dirty[0] | (iLine1 != shadow1);
   assign dirty2       = force_dirty[1] | (iLine2 != shadow2);
   // Round-robin only matters when both lines are dirty; otherwise take the dirty one.
   assign pick_line    = (dirty1 & dirty2) ? ~last_line : dirty2;
   assign cur_slot     = get_slot(snap, char_idx);
   assign settle_start = (state == S_WAIT) && iDone;
   assign oBusy        = (state != S_IDLE);

   lcd_settle_timer #(
      .DLY_CYCLES (DLY_CYCLES)
   ) u_settle (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .start   (settle_start),
      .expired (settle_expired)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state       <= S_INIT;
         ret_state   <= S_INIT;
         init_idx    <= '0;
         char_idx    <= '0;
         force_dirty <= 2'b11;
         // NOTE: the shadows are reset on purpose; with the force flags set they make the first pass redraw everything.
         shadow1     <= '0;
         shadow2     <= '0;
         snap        <= '0;
         sel_line    <= 1'b0;
         last_line   <= 1'b1;
         tx_byte     <= '0;
         tx_rs       <= 1'b0;
         oData       <= '0;
         oRS         <= 1'b0;
         oStart      <= 1'b0;
         oInitDone   <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               if (init_idx == 3'(INIT_LEN)) begin
                  oInitDone <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  tx_byte   <= init_byte(init_idx[1:0]);
                  tx_rs     <= 1'b0;
                  init_idx  <= init_idx + 3'd1;
                  ret_state <= S_INIT;
                  state     <= S_SEND;
               end
            end
            S_IDLE: begin
               if (dirty1 | dirty2) begin
                  sel_line               <= pick_line;
                  last_line              <= pick_line;
                  snap                   <= pick_line ? iLine2 : iLine1;
                  force_dirty[pick_line] <= 1'b0;
                  char_idx               <= '0;
                  state                  <= S_CURSOR;
               end
            end
            S_CURSOR: begin
               tx_byte   <= sel_line ? LCD_LINE2_ADDR : LCD_LINE1_ADDR;
               tx_rs     <= 1'b0;
               ret_state <= S_CHAR;
               state     <= S_SEND;
            end
            S_CHAR: begin
               tx_rs   <= cur_slot[CH_W-1];
               tx_byte <= cur_slot[7:0];
               if (char_idx == 4'(CHARS - 1)) begin
                  ret_state <= S_IDLE;
               end else begin
                  ret_state <= S_CHAR;
                  char_idx  <= char_idx + 4'd1;
               end
               state <= S_SEND;
            end
            S_SEND: begin
               oData  <= tx_byte;
               oRS    <= tx_rs;
               oStart <= 1'b1;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (iDone) begin
                  oStart <= 1'b0;
                  state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (settle_expired) begin
                  state <= ret_state;
                  // Returning to IDLE means the last char of a line just settled.
                  if (ret_state == S_IDLE) begin
                     if (sel_line) shadow2 <= snap;
                     else          shadow1 <= snap;
                  end
               end
            end
            default: state <= S_INIT;
         endcase

         // Written after the selection clear so a same-cycle refresh wins.
         if (iRefresh) force_dirty <= 2'b11;
      end
   end

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Self-checking bench: a transaction-level model predicts the byte stream and idle state.
module tb_lcd_refresh_scheduler;

   localparam int DLY = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [143:0] line1;
   logic [143:0] line2;
   logic         refresh = 1'b0;
   logic         done = 1'b0;
   logic [7:0]   data;
   logic         rs;
   logic         start;
   logic         busy;
   logic         init_done;

   lcd_refresh_scheduler #(
      .DLY_CYCLES (DLY)
   ) dut (
      .iCLK      (clk),
      .iRST_N    (rst_n),
      .iLine1    (line1),
      .iLine2    (line2),
      .iRefresh  (refresh),
      .iDone     (done),
      .oData     (data),
      .oRS       (rs),
      .oStart    (start),
      .oBusy     (busy),
      .oInitDone (init_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte writer: raises done 3 cycles after the start rise, drops it when start falls.
   int wcnt = 0;
   always @(posedge clk) begin
      #1;
      if (!start) begin
         done = 1'b0;
         wcnt = 0;
      end else begin
         wcnt++;
         if (wcnt >= 3) done = 1'b1;
      end
   end

   // Behavioural model: line state plus a queue of bytes still expected.
   logic [8:0]   exp_q[$];
   logic [8:0]   log_q[$];
   logic [143:0] m_shadow[2];
   logic [1:0]   m_force;
   logic         m_last;
   logic         pend_valid;
   logic         pend_line;
   logic [143:0] pend_snap;
   int           rise_cnt;
   int           idle_cnt = 0;
   logic         prev_start = 1'b0;
   logic [8:0]   prev_byte = '0;

   task automatic model_reset();
      exp_q       = {9'h038, 9'h00C, 9'h001, 9'h006};
      m_shadow[0] = '0;
      m_shadow[1] = '0;
      m_force     = 2'b11;
      m_last      = 1'b1;
      pend_valid  = 1'b0;
      rise_cnt    = 0;
      log_q.delete();
   endtask

   task automatic commit();
      m_shadow[pend_line] = pend_snap;
      pend_valid = 1'b0;
   endtask

   function automatic logic model_dirty();
      return m_force[0] | m_force[1] | (line1 != m_shadow[0]) | (line2 != m_shadow[1]);
   endfunction

   task automatic model_schedule();
      logic d1, d2, sel;
      logic [143:0] s;
      if (pend_valid) commit();
      d1 = m_force[0] | (line1 != m_shadow[0]);
      d2 = m_force[1] | (line2 != m_shadow[1]);
      if (!d1 && !d2) return;
      if (d1 && d2) sel = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else          sel = d2;
      s = sel ? line2 : line1;
      exp_q.push_back(sel ? 9'h0C0 : 9'h080);
      for (int k = 0; k < 16; k++) exp_q.push_back(s[143 - 9*k -: 9]);
      m_force[sel] = 1'b0;
      m_last       = sel;
      pend_valid   = 1'b1;
      pend_line    = sel;
      pend_snap    = s;
   endtask

   // Compare process: one pass per cycle, on the falling edge.
   always @(negedge clk) begin
      logic [8:0] cur;
      if (!rst_n) begin
         prev_start = 1'b0;
         prev_byte  = '0;
         idle_cnt   = 0;
      end else begin
         cur = {rs, data};
         if (start && !prev_start) begin
            if (exp_q.size() == 0) model_schedule();
            check("init_done_at_byte", init_done, (rise_cnt >= 4));
            rise_cnt++;
            log_q.push_back(cur);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got %0h expected none at %0t", cur, $time);
            end else begin
               check("byte", cur, exp_q.pop_front());
            end
         end else begin
            check("data_hold", cur, prev_byte);
         end
         if (!busy) idle_cnt++;
         else       idle_cnt = 0;
         if (idle_cnt >= 2) begin
            if (exp_q.size() == 0 && pend_valid) commit();
            check("idle_queue_empty", exp_q.size(), 0);
            check("idle_nothing_dirty", model_dirty(), 0);
            check("idle_init_done", init_done, 1);
         end
         prev_start = start;
         prev_byte  = cur;
      end
   end

   task automatic sync();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      sync();
      while (idle_cnt < 3 && n < 3000) begin
         sync();
         n++;
      end
      check({name, "_idle_reached"}, (idle_cnt >= 3), 1);
   endtask

   task automatic wait_log(input int count);
      int n = 0;
      while (log_q.size() < count && n < 3000) begin
         sync();
         n++;
      end
      check("wait_log_reached", (log_q.size() >= count), 1);
   endtask

   task automatic set_char(input int which, input int k, input logic [8:0] v);
      if (which == 1) line1[143 - 9*k -: 9] = v;
      else            line2[143 - 9*k -: 9] = v;
   endtask

   task automatic apply_reset();
      sync();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic pulse_refresh();
      sync();
      refresh = 1'b1;
      @(posedge clk);
      #1 refresh = 1'b0;
      @(negedge clk);
      #1 m_force = 2'b11;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      line1 = {16{9'h120}};
      line2 = {16{9'h120}};
      model_reset();
      #1;
      check("rst_data", data, 0);
      check("rst_rs", rs, 0);
      check("rst_start", start, 0);
      check("rst_busy", busy, 1);
      check("rst_init_done", init_done, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Power-up: init list then both lines of spaces.
      wait_idle("t1");
      check("t1_len", log_q.size(), 38);
      check("t1_b0", log_q[0], 9'h038);
      check("t1_b3", log_q[3], 9'h006);
      check("t1_cur1", log_q[4], 9'h080);
      check("t1_c0", log_q[5], 9'h120);
      check("t1_cur2", log_q[21], 9'h0C0);
      check("t1_busy", busy, 0);
      check("t1_init_done", init_done, 1);

      // Only line 2 changes.
      log_q.delete();
      sync();
      set_char(2, 5, 9'h141);
      wait_idle("t2");
      check("t2_len", log_q.size(), 17);
      check("t2_cur", log_q[0], 9'h0C0);
      check("t2_c4", log_q[5], 9'h120);
      check("t2_c5", log_q[6], 9'h141);

      // Line 1 changes again while its char 8 is in flight.
      log_q.delete();
      sync();
      set_char(1, 0, 9'h148);
      wait_log(10);
      set_char(1, 3, 9'h14C);
      wait_idle("t3");
      check("t3_len", log_q.size(), 34);
      check("t3_c0", log_q[1], 9'h148);
      check("t3_old_c3", log_q[4], 9'h120);
      check("t3_cur", log_q[17], 9'h080);
      check("t3_new_c3", log_q[21], 9'h14C);

      // Both change together, line 1 was served last.
      log_q.delete();
      sync();
      set_char(1, 15, 9'h15A);
      set_char(2, 15, 9'h15A);
      wait_idle("t4");
      check("t4_len", log_q.size(), 34);
      check("t4_first", log_q[0], 9'h0C0);
      check("t4_l2_c15", log_q[16], 9'h15A);
      check("t4_second", log_q[17], 9'h080);
      check("t4_l1_c15", log_q[33], 9'h15A);

      // Forced redraw while idle.
      log_q.delete();
      pulse_refresh();
      wait_idle("t5");
      check("t5_len", log_q.size(), 34);
      check("t5_first", log_q[0], 9'h0C0);
      check("t5_second", log_q[17], 9'h080);

      // Refresh during init: each line drawn exactly once afterwards.
      apply_reset();
      wait_log(2);
      pulse_refresh();
      wait_idle("t6");
      check("t6_len", log_q.size(), 38);
      check("t6_b0", log_q[0], 9'h038);
      check("t6_cur1", log_q[4], 9'h080);
      check("t6_cur2", log_q[21], 9'h0C0);

      // Reset during a settle inside the line-2 burst.
      apply_reset();
      wait_log(24);
      n = 0;
      while (start && n < 100) begin
         sync();
         n++;
      end
      sync();
      rst_n = 1'b0;
      #1;
      check("t7_rst_data", data, 0);
      check("t7_rst_rs", rs, 0);
      check("t7_rst_start", start, 0);
      check("t7_rst_busy", busy, 1);
      check("t7_rst_init_done", init_done, 0);
      model_reset();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_idle("t7");
      check("t7_len", log_q.size(), 38);
      check("t7_b0", log_q[0], 9'h038);
      check("t7_cur2", log_q[21], 9'h0C0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
